dac_frame_scheduler: RTL and testbench

Sequences sample delivery from the Xillybus DAC FIFO to the multi-channel DAC serializer. It reads one 32-bit FIFO word per channel and assembles NUM_CHANNELS words into a staging frame. On each frame boundary strobe from the serializer, it hands the frame over atomically. It keeps channel alignment across FIFO underruns and reports them; it sits between the FIFO and the DAC serializer in the capture_clk domain.

---
 rtl/dac_frame_scheduler.sv | 120 ++++++++++++
 tb/tb_dac_frame_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// Stages one FIFO word per DAC channel and hands the whole frame to the
// serializer on its frame strobe, holding channel alignment across underruns.
module dac_frame_scheduler #(
  parameter int NUM_CHANNELS     = 4,
  parameter int SAMPLE_BITS      = 24,
  parameter bit HOLD_ON_UNDERRUN = 1'b1,
  parameter int COUNT_BITS       = 16
) (
  input  logic                              capture_clk,
  input  logic                              reset_n,
  input  logic                              frame_strobe,
  output logic                              dac_rden,
  input  logic [31:0]                       dac_fifo_data,
  input  logic                              dac_empty,
  output logic [NUM_CHANNELS*SAMPLE_BITS-1:0] frame_data,
  output logic                              frame_valid,
  output logic                              running,
  output logic                              underrun,
  output logic [COUNT_BITS-1:0]             underrun_count
);

  localparam int CW = $clog2(NUM_CHANNELS + 1);
  localparam int FW = NUM_CHANNELS * SAMPLE_BITS;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CHANNELS);

  typedef enum logic {FILL, READY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_issued;
  logic [CW-1:0]   r_received;
  logic            r_rd_pend;
  logic [FW-1:0]   r_stage;
  logic [FW-1:0]   w_stage_nxt;
  logic [FW-1:0]   r_frame;
  logic            r_valid;
  logic            r_running;
  logic            r_underrun;
  logic [COUNT_BITS-1:0] r_count;
  logic            w_last;
  logic            w_deliver;
  logic            w_underrun;

  always_comb begin
    w_state_nxt = r_state;
    dac_rden    = 1'b0;
    w_last      = r_rd_pend && (r_received == LAST);
    w_deliver   = 1'b0;
    w_underrun  = 1'b0;
    unique case (r_state)
      FILL: begin
        dac_rden   = reset_n && !dac_empty &&
                     (r_issued < FULL);
        // final word landing with the strobe still completes the frame
        w_deliver  = frame_strobe && w_last;
        w_underrun = frame_strobe && !w_last &&
                     r_running;
        if (w_last && !frame_strobe)
          w_state_nxt = READY;
      end
      READY: begin
        w_deliver = frame_strobe;
        if (frame_strobe)
          w_state_nxt = FILL;
      end
    endcase
  end

  always_comb begin
    w_stage_nxt = r_stage;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (r_rd_pend && (r_received == CW'(k)))
        w_stage_nxt[k*SAMPLE_BITS +: SAMPLE_BITS] =
          dac_fifo_data[31 -: SAMPLE_BITS];
    end
  end

  always_ff @(posedge capture_clk) begin
    if (!reset_n) begin
      r_state    <= FILL;
      r_issued   <= '0;
      r_received <= '0;
      r_rd_pend  <= 1'b0;
      r_frame    <= '0;
      r_valid    <= 1'b0;
      r_running  <= 1'b0;
      r_underrun <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= dac_rden;
      r_stage   <= w_stage_nxt;
      r_valid   <= frame_strobe;
      if (w_deliver) begin
        r_frame    <= w_stage_nxt;
        r_running  <= 1'b1;
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        r_issued   <= r_issued + CW'(dac_rden);
        r_received <= r_received + CW'(r_rd_pend);
        if (w_underrun) begin
          r_underrun <= 1'b1;
          if (r_count != '1)
            r_count <= r_count + COUNT_BITS'(1);
          if (!HOLD_ON_UNDERRUN)
            r_frame <= '0;
        end
      end
    end
  end

  assign frame_data     = r_frame;
  assign frame_valid    = r_valid;
  assign running        = r_running;
  assign underrun       = r_underrun;
  assign underrun_count = r_count;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench: shared FIFO model feeding a hold-on-underrun
// instance and a zero-on-underrun instance in lockstep.
module tb_dac_frame_scheduler;

  logic        clk;
  logic        reset_n;
  logic        frame_strobe;
  logic        dac_empty;
  logic [31:0] dac_fifo_data;

  logic        rden0;
  logic [95:0] frame0;
  logic        valid0;
  logic        run0;
  logic        und0;
  logic [15:0] cnt0;

  logic        rden1;
  logic [95:0] frame1;
  logic        valid1;
  logic        run1;
  logic        und1;
  logic [15:0] cnt1;

  logic [31:0] mem [0:63];
  int          wr_ptr;
  int          rd_ptr;
  int          bad_rd;
  int          vectors;
  int          errs;
  logic [9:0]  pat;

  localparam logic [95:0] F1 = 96'h444444_333333_222222_111111;
  localparam logic [95:0] F2 = 96'h888888_777777_666666_555555;
  localparam logic [95:0] F3 = 96'hA0B0C0_708090_405060_102030;
  localparam logic [95:0] F4 = 96'hC40000_C30000_C20000_C10000;

  dac_frame_scheduler #(
    .HOLD_ON_UNDERRUN(1'b1)
  ) dut0 (
    .capture_clk   (clk),
    .reset_n       (reset_n),
    .frame_strobe  (frame_strobe),
    .dac_rden      (rden0),
    .dac_fifo_data (dac_fifo_data),
    .dac_empty     (dac_empty),
    .frame_data    (frame0),
    .frame_valid   (valid0),
    .running       (run0),
    .underrun      (und0),
    .underrun_count(cnt0)
  );

  dac_frame_scheduler #(
    .HOLD_ON_UNDERRUN(1'b0)
  ) dut1 (
    .capture_clk   (clk),
    .reset_n       (reset_n),
    .frame_strobe  (frame_strobe),
    .dac_rden      (rden1),
    .dac_fifo_data (dac_fifo_data),
    .dac_empty     (dac_empty),
    .frame_data    (frame1),
    .frame_valid   (valid1),
    .running       (run1),
    .underrun      (und1),
    .underrun_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dac_empty = (rd_ptr == wr_ptr);

  initial begin
    rd_ptr        = 0;
    bad_rd        = 0;
    dac_fifo_data = 32'h0;
  end

  always @(posedge clk) begin
    if (rden0 && dac_empty)
      bad_rd <= bad_rd + 1;
    if (rden0) begin
      dac_fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic strobe_once;
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    errs         = 0;
    wr_ptr       = 0;
    reset_n      = 1'b0;
    frame_strobe = 1'b0;
    push(32'h11111100);
    push(32'h22222200);
    push(32'h33333300);
    push(32'h44444400);
    repeat (3) @(negedge clk);

    chk("rst_rden", 96'(rden0), 96'd0);
    chk("rst_frame", frame0, 96'd0);
    chk("rst_valid", 96'(valid0), 96'd0);
    chk("rst_running", 96'(run0), 96'd0);
    chk("rst_underrun", 96'(und0), 96'd0);
    chk("rst_count", 96'(cnt0), 96'd0);

    // test 1: four back-to-back reads then delivery
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 pat[i] = rden0;
      @(negedge clk);
    end
    chk("t1_rden_pattern", 96'(pat), 96'h00F);
    chk("t1_pops", 96'(rd_ptr), 96'd4);
    chk("t1_valid_pre", 96'(valid0), 96'd0);
    strobe_once();
    chk("t1_valid", 96'(valid0), 96'd1);
    chk("t1_frame", frame0, F1);
    chk("t1_frame_z", frame1, F1);
    chk("t1_running", 96'(run0), 96'd1);
    chk("t1_underrun", 96'(und0), 96'd0);
    @(negedge clk);
    chk("t1_valid_drop", 96'(valid0), 96'd0);

    // tests 2/3: underrun with one word staged
    push(32'h55555500);
    repeat (3) @(negedge clk);
    strobe_once();
    chk("t2_valid", 96'(valid0), 96'd1);
    chk("t2_frame_hold", frame0, F1);
    chk("t3_frame_zero", frame1, 96'd0);
    chk("t3_valid", 96'(valid1), 96'd1);
    chk("t2_underrun", 96'(und0), 96'd1);
    chk("t2_count", 96'(cnt0), 96'd1);
    chk("t3_count", 96'(cnt1), 96'd1);
    push(32'h66666600);
    push(32'h77777700);
    push(32'h88888800);
    repeat (6) @(negedge clk);
    strobe_once();
    chk("t2_frame_new", frame0, F2);
    chk("t3_frame_new", frame1, F2);
    chk("t2_count_keep", 96'(cnt0), 96'd1);
    chk("t2_underrun_sticky", 96'(und0), 96'd1);

    // test 4: strobe on the cycle the last word lands
    push(32'h10203000);
    push(32'h40506000);
    push(32'h708090FF);
    push(32'hA0B0C0DE);
    repeat (4) @(negedge clk);
    strobe_once();
    chk("t4_valid", 96'(valid0), 96'd1);
    chk("t4_frame", frame0, F3);
    chk("t4_count", 96'(cnt0), 96'd1);

    // drive count up to 5 with empty-FIFO underruns
    for (int i = 0; i < 4; i++) begin
      strobe_once();
      @(negedge clk);
    end
    chk("t6_count5", 96'(cnt0), 96'd5);
    chk("t6_hold_frame", frame0, F3);
    chk("t6_zero_frame", frame1, 96'd0);

    // test 6: reset mid-frame with a read outstanding
    push(32'hDEAD0100);
    push(32'hDEAD0200);
    push(32'hDEAD0300);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1 chk("t6_rden_gated", 96'(rden0), 96'd0);
    @(negedge clk);
    chk("t6_frame", frame0, 96'd0);
    chk("t6_valid", 96'(valid0), 96'd0);
    chk("t6_running", 96'(run0), 96'd0);
    chk("t6_underrun", 96'(und0), 96'd0);
    chk("t6_count", 96'(cnt0), 96'd0);
    chk("t6_pops", 96'(rd_ptr), 96'(wr_ptr));

    // test 5: startup strobes, one cycle apart
    reset_n = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b1;
    @(negedge clk);
    chk("t5_valid_a", 96'(valid0), 96'd1);
    chk("t5_frame_a", frame0, 96'd0);
    @(negedge clk);
    frame_strobe = 1'b0;
    chk("t5_valid_b", 96'(valid0), 96'd1);
    chk("t5_frame_b", frame0, 96'd0);
    chk("t5_underrun", 96'(und0), 96'd0);
    chk("t5_count", 96'(cnt0), 96'd0);
    chk("t5_running", 96'(run0), 96'd0);
    chk("t5_no_pop", 96'(rd_ptr), 96'(wr_ptr));

    // fresh frame after reset starts at channel 0
    push(32'hC1000000);
    push(32'hC2000000);
    push(32'hC3000000);
    push(32'hC4000000);
    repeat (8) @(negedge clk);
    strobe_once();
    chk("t6_fresh_frame", frame0, F4);
    chk("t6_fresh_running", 96'(run0), 96'd1);
    chk("t6_fresh_count", 96'(cnt0), 96'd0);
    chk("rden_lockstep", 96'(rden1), 96'(rden0));
    chk("no_rden_when_empty", 96'(bad_rd), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
